// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the iterative multiply/divide unit and the control
// logic that drives its start/write strobes.
package mult_div_unit_pkg;

  localparam int MDU_WIDTH = 32;

  // Enough bits to count WIDTH iterations (6 bits for a 32-bit datapath).
  function automatic int iter_cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

  localparam int MDU_CNT_W = iter_cnt_width(MDU_WIDTH);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD     = 3'd1,
    MUL_ITER = 3'd2,
    DIV_ITER = 3'd3,
    FINISH   = 3'd4
  } mdu_state_e;

  typedef enum logic {
    OP_MUL = 1'b0,
    OP_DIV = 1'b1
  } mdu_op_e;

endpackage

// File: rtl/mult_div_unit_div_sign_fix.sv
// Converts unsigned quotient/remainder magnitudes into signed results; also
// reused to take operand absolute values before a divide starts.
module div_sign_fix
  import mult_div_unit_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic [WIDTH-1:0] quot_mag,
  input  logic [WIDTH-1:0] rem_mag,
  input  logic             dividend_neg,
  input  logic             divisor_neg,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem
);

  // Quotient is negative when operand signs differ; remainder follows the dividend.
  always_comb begin
    quot = (dividend_neg ^ divisor_neg) ? -quot_mag : quot_mag;
    rem  = dividend_neg ? -rem_mag : rem_mag;
  end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative signed multiply (radix-2 Booth) / divide (restoring) unit feeding
// the HI/LO registers of the multicycle MIPS datapath.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_mult,
  input  logic             start_div,
  input  logic             hi_write,
  input  logic             lo_write,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic             busy,
  output logic             done,
  output logic             DIV_ZERO
);

  localparam int CNT_W = iter_cnt_width(WIDTH);
  localparam int AW    = 2 * WIDTH + 1;

  mdu_state_e       state, state_next;
  mdu_op_e          op;
  logic [AW-1:0]    acc;
  logic [WIDTH-1:0] m;
  logic [CNT_W-1:0] cnt;
  logic             a_neg, b_neg;
  logic             last_iter, div_by_zero;
  logic [WIDTH:0]   booth_a, booth_m, booth_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH+1:0] div_diff;
  logic [WIDTH-1:0] fix_q_in, fix_r_in, fix_q, fix_r;
  logic             fix_divisor_neg;

  assign last_iter   = (cnt == CNT_W'(WIDTH - 1));
  assign div_by_zero = (op == OP_DIV) && (m == '0);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: every combinational output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (start_mult || start_div) state_next = LOAD;
      LOAD: begin
        if (div_by_zero)        state_next = IDLE;
        else if (op == OP_MUL)  state_next = MUL_ITER;
        else                    state_next = DIV_ITER;
      end
      MUL_ITER,
      DIV_ITER: if (last_iter) state_next = FINISH;
      FINISH:   state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
  end

  // Booth step: the add is done one bit wider so the arithmetic shift
  // always brings in the true sign, even for a most-negative multiplicand.
  always_comb begin
    booth_a = {acc[AW-1], acc[AW-1:WIDTH+1]};
    booth_m = {m[WIDTH-1], m};
    case (acc[1:0])
      2'b01:   booth_sum = booth_a + booth_m;
      2'b10:   booth_sum = booth_a - booth_m;
      default: booth_sum = booth_a;
    endcase
    div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_diff  = {1'b0, div_shift} - {2'b00, m};
  end

  // In LOAD the sign fixer yields |SrcB| on quot and |SrcA| on rem.
  always_comb begin
    if (state == LOAD) begin
      fix_q_in        = m;
      fix_r_in        = acc[WIDTH-1:0];
      fix_divisor_neg = a_neg ^ b_neg;
    end else begin
      fix_q_in        = acc[WIDTH-1:0];
      fix_r_in        = acc[2*WIDTH-1:WIDTH];
      fix_divisor_neg = b_neg;
    end
  end

  div_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
    .quot_mag     (fix_q_in),
    .rem_mag      (fix_r_in),
    .dividend_neg (a_neg),
    .divisor_neg  (fix_divisor_neg),
    .quot         (fix_q),
    .rem          (fix_r)
  );

  // NOTE: the datapath registers are few and flop-based, so all of them are
  // reset; nothing here is a RAM that would need to stay unreset.
  always_ff @(posedge clk) begin
    if (reset) begin
      HI       <= '0;
      LO       <= '0;
      acc      <= '0;
      m        <= '0;
      cnt      <= '0;
      op       <= OP_MUL;
      a_neg    <= 1'b0;
      b_neg    <= 1'b0;
      done     <= 1'b0;
      DIV_ZERO <= 1'b0;
    end else begin
      done     <= 1'b0;
      DIV_ZERO <= 1'b0;
      case (state)
        IDLE: begin
          if (start_mult) begin
            op  <= OP_MUL;
            m   <= SrcA;
            acc <= {{WIDTH{1'b0}}, SrcB, 1'b0};
          end else if (start_div) begin
            op    <= OP_DIV;
            m     <= SrcB;
            acc   <= {{(WIDTH+1){1'b0}}, SrcA};
            a_neg <= SrcA[WIDTH-1];
            b_neg <= SrcB[WIDTH-1];
          end else begin
            if (hi_write) HI <= SrcA;
            if (lo_write) LO <= SrcA;
          end
        end
        LOAD: begin
          cnt <= '0;
          if (div_by_zero) begin
            done     <= 1'b1;
            DIV_ZERO <= 1'b1;
          end else if (op == OP_DIV) begin
            acc <= {{(WIDTH+1){1'b0}}, fix_r};
            m   <= fix_q;
          end
        end
        MUL_ITER: begin
          acc <= {booth_sum, acc[WIDTH:1]};
          cnt <= cnt + CNT_W'(1);
        end
        DIV_ITER: begin
          if (!div_diff[WIDTH+1]) acc <= {div_diff[WIDTH:0], acc[WIDTH-2:0], 1'b1};
          else                    acc <= {div_shift, acc[WIDTH-2:0], 1'b0};
          cnt <= cnt + CNT_W'(1);
        end
        FINISH: begin
          done <= 1'b1;
          if (op == OP_MUL) begin
            HI <= acc[AW-1:WIDTH+1];
            LO <= acc[WIDTH:1];
          end else begin
            HI <= fix_r;
            LO <= fix_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Randomised and directed bench for mult_div_unit with a queue-based
// scoreboard and an arithmetic reference model.
module tb_mult_div_unit;

  localparam int W = 32;

  typedef enum int {K_MULT, K_DIV, K_MTHI, K_MTLO} kind_e;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
    int           id;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset, start_mult, start_div, hi_write, lo_write;
  logic [W-1:0] SrcA, SrcB, HI, LO;
  logic         busy, done, DIV_ZERO;

  int           checks = 0;
  int           errors = 0;
  int           op_id  = 0;
  exp_t         sb[$];
  logic [W-1:0] model_hi, model_lo;

  mult_div_unit #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start_mult (start_mult),
    .start_div  (start_div),
    .hi_write   (hi_write),
    .lo_write   (lo_write),
    .SrcA       (SrcA),
    .SrcB       (SrcB),
    .HI         (HI),
    .LO         (LO),
    .busy       (busy),
    .done       (done),
    .DIV_ZERO   (DIV_ZERO)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void model_mult(input logic [W-1:0] a, input logic [W-1:0] b,
                                     output logic [W-1:0] h, output logic [W-1:0] l);
    logic signed [2*W-1:0] p;
    p = $signed({{W{a[W-1]}}, a}) * $signed({{W{b[W-1]}}, b});
    {h, l} = p;
  endfunction

  function automatic void model_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                    output logic [W-1:0] q, output logic [W-1:0] r);
    int na, nb;
    na = a;
    nb = b;
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = a;
      r = '0;
    end else begin
      q = na / nb;
      r = na % nb;
    end
  endfunction

  function automatic logic [W-1:0] rand_word();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h7FFF_FFFF;
      4:       return W'($urandom_range(0, 15));
      5:       return -W'($urandom_range(1, 15));
      default: return $urandom;
    endcase
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (DIV_ZERO) check("div_zero_implies_done", done, 1);
      if (done) begin
        check("busy_low_in_done", busy, 0);
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=1 expected no pending operation");
        end else begin
          e = sb.pop_front();
          check($sformatf("op%0d_hi", e.id), HI, e.hi);
          check($sformatf("op%0d_lo", e.id), LO, e.lo);
          check($sformatf("op%0d_div_zero", e.id), DIV_ZERO, e.dz);
        end
      end
    end
  end

  task automatic clear_inputs();
    start_mult = 1'b0;
    start_div  = 1'b0;
    hi_write   = 1'b0;
    lo_write   = 1'b0;
  endtask

  task automatic issue(input kind_e kind, input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit disturb, input bit extra);
    exp_t         e;
    int           exp_lat;
    bit           got;
    logic [W-1:0] old_hi, old_lo;
    old_hi = model_hi;
    old_lo = model_lo;
    e.id   = op_id++;
    e.dz   = 1'b0;
    e.hi   = model_hi;
    e.lo   = model_lo;
    case (kind)
      K_MULT: model_mult(a, b, e.hi, e.lo);
      K_DIV: begin
        if (b == '0) e.dz = 1'b1;
        else         model_div(a, b, e.lo, e.hi);
      end
      K_MTHI: e.hi = a;
      K_MTLO: e.lo = a;
      default: ;
    endcase
    model_hi   = e.hi;
    model_lo   = e.lo;
    SrcA       = a;
    SrcB       = b;
    start_mult = (kind == K_MULT);
    start_div  = (kind == K_DIV) || (extra && kind == K_MULT);
    hi_write   = (kind == K_MTHI) || (extra && kind != K_MTLO);
    lo_write   = (kind == K_MTLO) || (extra && kind == K_DIV);
    if (kind == K_MULT || kind == K_DIV) sb.push_back(e);
    @(posedge clk);
    #1;
    clear_inputs();
    SrcA = $urandom;
    SrcB = $urandom;
    if (kind == K_MTHI || kind == K_MTLO) begin
      check($sformatf("op%0d_write_hi", e.id), HI, model_hi);
      check($sformatf("op%0d_write_lo", e.id), LO, model_lo);
      check($sformatf("op%0d_write_no_done", e.id), done, 0);
      return;
    end
    check($sformatf("op%0d_busy_after_start", e.id), busy, 1);
    exp_lat = (kind == K_DIV && b == '0) ? 1 : W + 2;
    got     = 1'b0;
    for (int c = 1; c <= W + 20 && !got; c++) begin
      if (disturb && c == 5) begin
        start_mult = 1'b1;
        start_div  = 1'b1;
        hi_write   = 1'b1;
        lo_write   = 1'b1;
        SrcB       = '0;
      end
      @(posedge clk);
      #1;
      if (disturb && c == 5) begin
        clear_inputs();
        check($sformatf("op%0d_hi_held_while_busy", e.id), HI, old_hi);
        check($sformatf("op%0d_lo_held_while_busy", e.id), LO, old_lo);
      end
      if (done) begin
        got = 1'b1;
        check($sformatf("op%0d_latency", e.id), c, exp_lat);
      end else begin
        check($sformatf("op%0d_busy_during_op", e.id), busy, 1);
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL op%0d_done_timeout: got no done expected done after %0d cycles", e.id, exp_lat);
      void'(sb.pop_back());
    end
  endtask

  task automatic reset_abort();
    SrcA       = 32'd1234;
    SrcB       = 32'd5678;
    start_mult = 1'b1;
    @(posedge clk);
    #1;
    clear_inputs();
    repeat (11) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset    = 1'b0;
    model_hi = '0;
    model_lo = '0;
    check("abort_hi", HI, 0);
    check("abort_lo", LO, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    repeat (W + 8) @(posedge clk);
    #1;
    check("abort_stays_idle", busy, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    clear_inputs();
    SrcA     = '0;
    SrcB     = '0;
    model_hi = '0;
    model_lo = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check("reset_hi", HI, 0);
    check("reset_lo", LO, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_div_zero", DIV_ZERO, 0);

    issue(K_MULT, 32'd7, 32'hFFFF_FFFD, 1'b0, 1'b0);
    issue(K_MULT, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
    issue(K_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
    issue(K_DIV, 32'd7, 32'hFFFF_FFFE, 1'b0, 1'b0);
    issue(K_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    issue(K_MTHI, 32'h11, 32'h0, 1'b0, 1'b0);
    issue(K_MTLO, 32'h22, 32'h0, 1'b0, 1'b0);
    issue(K_DIV, 32'd5, 32'd0, 1'b0, 1'b0);
    issue(K_MTHI, 32'hCAFE, 32'h0, 1'b0, 1'b0);
    issue(K_MULT, 32'd12345, 32'hFFFF_FD5A, 1'b1, 1'b1);
    issue(K_DIV, 32'hFFFF_0000, 32'd3, 1'b1, 1'b1);
    reset_abort();

    for (int i = 0; i < 60; i++) begin
      issue(kind_e'($urandom_range(0, 3)), rand_word(), rand_word(),
            ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) == 0));
    end

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
